// File: rtl/tl_burst_arbiter.sv
// Round-robin TileLink A/C channel arbiter: one grant per message, locked for
// every beat of a multi-beat burst so beats from different hosts never interleave.

// Extra beats (beats-1) a message occupies beyond its first beat.
module tl_burst_beats #(
  parameter int DataWidth = 128,
  parameter int SizeWidth = 3,
  parameter int CntW      = 2
) (
  input  logic [SizeWidth-1:0] size,
  input  logic                 has_data,
  output logic [CntW-1:0]      extra
);
  localparam int LogBytes = $clog2(DataWidth / 8);

  always_comb begin
    extra = '0;
    if (has_data && int'(size) > LogBytes)
      extra = CntW'((1 << (int'(size) - LogBytes)) - 1);
  end
endmodule

module tl_burst_arbiter #(
  parameter int NumHosts     = 3,
  parameter int DataWidth    = 128,
  parameter int SizeWidth    = 3,
  parameter int MaxSize      = 6,
  parameter int PayloadWidth = 64
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NumHosts-1:0]                      req_valid_i,
  output logic [NumHosts-1:0]                      req_ready_o,
  input  logic [NumHosts-1:0][SizeWidth-1:0]       req_size_i,
  input  logic [NumHosts-1:0]                      req_has_data_i,
  input  logic [NumHosts-1:0][PayloadWidth-1:0]    req_payload_i,
  output logic                                     dev_valid_o,
  input  logic                                     dev_ready_i,
  output logic [SizeWidth-1:0]                     dev_size_o,
  output logic                                     dev_has_data_o,
  output logic [PayloadWidth-1:0]                  dev_payload_o,
  output logic [$clog2(NumHosts)-1:0]              grant_idx_o,
  output logic                                     locked_o
);
  localparam int IdxW     = $clog2(NumHosts);
  localparam int LogBytes = $clog2(DataWidth / 8);
  localparam int CntW     = (MaxSize > LogBytes) ? (MaxSize - LogBytes) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                     state;
  logic [IdxW-1:0]            owner, last_winner, base, winner, sel;
  logic [CntW-1:0]            beats_left;
  logic [NumHosts-1:0][CntW-1:0] extra;
  logic                       locked, hs;

  for (genvar h = 0; h < NumHosts; h++) begin : g_host
    tl_burst_beats #(
      .DataWidth (DataWidth),
      .SizeWidth (SizeWidth),
      .CntW      (CntW)
    ) u_beats (
      .size     (req_size_i[h]),
      .has_data (req_has_data_i[h]),
      .extra    (extra[h])
    );
  end

  // Reset is folded in combinationally so outputs already show the IDLE,
  // host-0-first view while rst_i is held.
  assign locked = (state == BURST) && !rst_i;

  always_comb begin
    base   = rst_i ? IdxW'(NumHosts - 1) : last_winner;
    winner = IdxW'((int'(base) + 1) % NumHosts);
    // Descending scan: the closest valid host after base is assigned last.
    for (int k = NumHosts; k >= 1; k--) begin
      if (req_valid_i[(int'(base) + k) % NumHosts])
        winner = IdxW'((int'(base) + k) % NumHosts);
    end
  end

  assign sel            = locked ? owner : winner;
  assign dev_valid_o    = req_valid_i[sel];
  assign dev_size_o     = req_size_i[sel];
  assign dev_has_data_o = req_has_data_i[sel];
  assign dev_payload_o  = req_payload_i[sel];
  assign grant_idx_o    = sel;
  assign locked_o       = locked;
  assign hs             = dev_valid_o && dev_ready_i;

  always_comb begin
    req_ready_o      = '0;
    req_ready_o[sel] = dev_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      owner       <= '0;
      beats_left  <= '0;
      last_winner <= IdxW'(NumHosts - 1);
    end else begin
      case (state)
        IDLE: if (hs) begin
          last_winner <= winner;
          if (extra[winner] != '0) begin
            state      <= BURST;
            owner      <= winner;
            beats_left <= extra[winner];
          end
        end
        BURST: if (hs) begin
          beats_left <= beats_left - CntW'(1);
          if (beats_left == CntW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tl_burst_arbiter.sv
// Directed bench for tl_burst_arbiter: host message queues drive the DUT, a
// message-level model checks every cycle, literal grant orders pin the model.
module tb_tl_burst_arbiter;
  localparam int N = 3, SW = 3, PW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]          req_valid, req_ready, req_has_data;
  logic [N-1:0][SW-1:0]  req_size;
  logic [N-1:0][PW-1:0]  req_payload;
  logic                  dev_valid, dev_ready, dev_has_data, locked;
  logic [SW-1:0]         dev_size;
  logic [PW-1:0]         dev_payload;
  logic [1:0]            grant_idx;

  tl_burst_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_size_i(req_size),
    .req_has_data_i(req_has_data), .req_payload_i(req_payload),
    .dev_valid_o(dev_valid), .dev_ready_i(dev_ready), .dev_size_o(dev_size),
    .dev_has_data_o(dev_has_data), .dev_payload_o(dev_payload),
    .grant_idx_o(grant_idx), .locked_o(locked)
  );

  typedef struct {int size; bit hd; int beats;} msg_t;

  int   checks = 0, failures = 0;
  msg_t q[N][$];
  int   beat[N], sent[N];
  bit   hold[N];
  bit   rdy = 1'b1;
  bit [N-1:0] hs_seen;
  int   log_h[$], log_l[$];
  int   m_last = N - 1, m_owner = 0, m_left = 0;
  bit   m_locked = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(int base, logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(base + k) % N]) return (base + k) % N;
    return (base + 1) % N;
  endfunction

  function automatic int nbeats(int size, bit hd);
    return (hd && size > 4) ? (1 << (size - 4)) : 1;
  endfunction

  // Model: expected outputs from message-level state, then advance it.
  always @(negedge clk) begin
    int base, sel, n;
    bit elock, ev, hs;
    base  = rst ? N - 1 : m_last;
    elock = !rst && m_locked;
    sel   = elock ? m_owner : pick(base, req_valid);
    ev    = req_valid[sel];
    chk("dev_valid", dev_valid, ev);
    chk("grant_idx", grant_idx, sel);
    chk("locked", locked, elock);
    chk("req_ready", req_ready, dev_ready ? (1 << sel) : 0);
    if (ev) begin
      chk("dev_payload", dev_payload, req_payload[sel]);
      chk("dev_size", dev_size, req_size[sel]);
      chk("dev_has_data", dev_has_data, req_has_data[sel]);
    end
    hs = ev && dev_ready;
    hs_seen = '0;
    if (rst) begin
      m_last = N - 1; m_locked = 0; m_owner = 0; m_left = 0;
    end else if (hs) begin
      hs_seen[sel] = 1'b1;
      log_h.push_back(sel);
      log_l.push_back(int'(elock));
      if (m_locked) begin
        m_left--;
        if (m_left == 0) m_locked = 0;
      end else begin
        m_last = sel;
        n = nbeats(int'(req_size[sel]), req_has_data[sel]);
        if (n > 1) begin m_locked = 1; m_owner = sel; m_left = n - 1; end
      end
    end
  end

  task automatic drive();
    for (int h = 0; h < N; h++) begin
      req_valid[h] = (q[h].size() > 0) && !hold[h];
      req_size[h] = '0;
      req_has_data[h] = 1'b0;
      if (q[h].size() > 0) begin
        req_size[h] = SW'(q[h][0].size);
        req_has_data[h] = q[h][0].hd;
      end
      req_payload[h] = {8'(h), 8'(beat[h]), 16'(sent[h]), 32'hC0DE_0000 | 32'(h)};
    end
    dev_ready = rdy;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int h = 0; h < N; h++) begin
      if (hs_seen[h] && q[h].size() > 0) begin
        beat[h]++;
        if (beat[h] == q[h][0].beats) begin
          void'(q[h].pop_front());
          beat[h] = 0;
          sent[h]++;
        end
      end
    end
    drive();
  endtask

  task automatic push(int h, int size, bit hd, int beats, int count);
    msg_t m;
    m.size = size; m.hd = hd; m.beats = beats;
    repeat (count) q[h].push_back(m);
  endtask

  function automatic bit pending();
    for (int h = 0; h < N; h++) if (q[h].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(string name, int bound);
    int c = 0;
    while (pending() && c < bound) begin cycle(); c++; end
    chk({name, "_timeout"}, pending(), 0);
  endtask

  task automatic expect_log(string name, int eh[$], int el[$]);
    chk({name, "_count"}, log_h.size(), eh.size());
    for (int i = 0; i < eh.size() && i < log_h.size(); i++) begin
      chk({name, "_host"}, log_h[i], eh[i]);
      if (el.size() > 0) chk({name, "_lock"}, log_l[i], el[i]);
    end
  endtask

  initial begin
    int eh[$], el[$], c, cnt[N], last_seen[N], max_wait;
    drive();
    // Reset with all hosts idle.
    cycle(); cycle();
    #1;
    chk("rst_grant", grant_idx, 0);
    chk("rst_locked", locked, 0);
    chk("rst_valid", dev_valid, 0);
    rst = 1'b0;
    cycle();
    #1;
    chk("idle_grant", grant_idx, 0);

    // Single-beat alternation between hosts 0 and 2.
    log_h.delete(); log_l.delete();
    push(0, 3, 0, 1, 3); push(2, 3, 0, 1, 3);
    drive();
    drain("t1", 50);
    eh = {0, 2, 0, 2, 0, 2}; el = {0, 0, 0, 0, 0, 0};
    expect_log("t1", eh, el);

    // Host 1 four-beat burst stays locked while 0 and 2 wait.
    log_h.delete(); log_l.delete();
    push(1, 6, 1, 4, 1); push(0, 3, 0, 1, 1); push(2, 3, 0, 1, 1);
    drive();
    drain("t2", 50);
    eh = {0, 1, 1, 1, 1, 2}; el = {0, 0, 1, 1, 1, 0};
    expect_log("t2", eh, el);

    // Owner drops valid for 3 cycles mid-burst.
    log_h.delete(); log_l.delete();
    push(0, 6, 1, 4, 1); push(1, 3, 0, 1, 1); push(2, 3, 0, 1, 1);
    drive();
    c = 0;
    while (log_h.size() < 2 && c < 50) begin cycle(); c++; end
    chk("t3_reach", log_h.size(), 2);
    hold[0] = 1'b1;
    drive();
    repeat (3) begin
      #1;
      chk("t3_stall_valid", dev_valid, 0);
      chk("t3_stall_grant", grant_idx, 0);
      cycle();
    end
    hold[0] = 1'b0;
    drive();
    drain("t3", 50);
    eh = {0, 0, 0, 0, 1, 2}; el = {0, 1, 1, 1, 0, 0};
    expect_log("t3", eh, el);

    // Random ready during a two-beat burst.
    log_h.delete(); log_l.delete();
    push(1, 5, 1, 2, 1);
    drive();
    c = 0;
    while (pending() && c < 200) begin
      cycle();
      rdy = 1'($urandom_range(0, 1));
      drive();
      c++;
    end
    chk("t4_timeout", pending(), 0);
    rdy = 1'b1;
    drive();
    eh = {1, 1}; el = {0, 1};
    expect_log("t4", eh, el);
    #1;
    chk("t4_next_grant", grant_idx, 2);
    chk("t4_unlocked", locked, 0);

    // Reset after beat 2 of a four-beat burst.
    log_h.delete(); log_l.delete();
    push(2, 6, 1, 4, 1);
    drive();
    c = 0;
    while (log_h.size() < 2 && c < 50) begin cycle(); c++; end
    chk("t5_reach", log_h.size(), 2);
    rst = 1'b1;
    for (int h = 0; h < N; h++) begin q[h].delete(); beat[h] = 0; end
    drive();
    #1;
    chk("t5_rst_locked", locked, 0);
    chk("t5_rst_grant", grant_idx, 0);
    cycle();
    rst = 1'b0;
    drive();
    #1;
    chk("t5_post_locked", locked, 0);
    chk("t5_post_grant", grant_idx, 0);
    log_h.delete(); log_l.delete();
    push(2, 3, 0, 1, 1); push(1, 3, 0, 1, 1); push(0, 3, 0, 1, 1);
    drive();
    drain("t5", 50);
    eh = {0, 1, 2}; el = {};
    expect_log("t5", eh, el);

    // Fairness: three hosts saturated for 300 cycles.
    log_h.delete(); log_l.delete();
    for (int h = 0; h < N; h++) push(h, 2, 0, 1, 101);
    drive();
    repeat (300) cycle();
    chk("t6_total", log_h.size(), 300);
    for (int h = 0; h < N; h++) begin cnt[h] = 0; last_seen[h] = -1; end
    max_wait = 0;
    foreach (log_h[i]) begin
      int h, w;
      h = log_h[i];
      cnt[h]++;
      w = i - last_seen[h] - 1;
      if (w > max_wait) max_wait = w;
      last_seen[h] = i;
    end
    for (int h = 0; h < N; h++) chk("t6_share", (cnt[h] >= 99 && cnt[h] <= 101), 1);
    chk("t6_max_wait_le2", max_wait <= 2, 1);
    eh = {0, 1, 2};
    for (int i = 0; i < 3; i++) chk("t6_order", log_h[i], eh[i]);
    for (int h = 0; h < N; h++) begin q[h].delete(); beat[h] = 0; end
    drive();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tl_burst_arbiter.md
# tl_burst_arbiter

Round-robin arbiter that shares one TileLink request channel (A or C) between `NumHosts` upstream links. It is the channel scheduler inside the host aggregation path, between the per-core and DMA source shifters and the downstream register slice. It grants one host per message and locks that grant for every beat of a multi-beat burst, so beats from different hosts never interleave. A new grant is issued only on a message boundary, with rotating priority.

## Interface
- `NumHosts`, 3: number of requesting links; must be ≥2.
- `DataWidth`, 128: channel data width in bits; power of two, ≥8.
- `SizeWidth`, 3: width of the TileLink `size` field (log2 bytes).
- `MaxSize`, 6: largest legal `size`; sets beat counter width.
- `PayloadWidth`, 64: opaque per-beat payload (opcode, param, source, address, mask, data, corrupt) muxed unchanged.

- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  NumHosts  per-host beat valid.
- `req_ready_o`  out  NumHosts  per-host beat ready.
- `req_size_i`  in  NumHosts×SizeWidth  per-host message size.
- `req_has_data_i`  in  NumHosts  message carries data (multi-beat capable).
- `req_payload_i`  in  NumHosts×PayloadWidth  per-host beat payload.
- `dev_valid_o`  out  1  downstream beat valid.
- `dev_ready_i`  in  1  downstream ready.
- `dev_size_o`  out  SizeWidth  size of forwarded beat.
- `dev_has_data_o`  out  1  has_data of forwarded beat.
- `dev_payload_o`  out  PayloadWidth  forwarded payload.
- `grant_idx_o`  out  $clog2(NumHosts)  index of the currently selected host.
- `locked_o`  out  1  a burst is in progress and the grant is frozen.

## Operation
- State: `locked` (1b), `owner` (index), `beats_left` (counter), `last_winner` (index).
- Beats per message: `has_data` and `size > log2(DataWidth/8)` gives `2^(size − log2(DataWidth/8))`. Otherwise 1. With DataWidth=128: size 6 → 4 beats; size ≤4 → 1 beat.
- IDLE (`locked`=0): the winner is the first valid host scanning `last_winner+1, +2, …` modulo NumHosts. Selection is combinational in the same cycle. `dev_*` = winner's signals; `req_ready_o[winner]` = `dev_ready_i`; all other readies are 0. If no host is valid, `dev_valid_o`=0 and `grant_idx_o` = `last_winner+1` mod NumHosts.
- On an IDLE handshake (`dev_valid_o && dev_ready_i`): `last_winner` ← winner.
  - If beats > 1: `locked` ← 1, `owner` ← winner, `beats_left` ← beats−1.
  - Otherwise stay IDLE.
- LOCKED: the mux is fixed to `owner` regardless of other valids. `dev_valid_o` = `req_valid_i[owner]`, so a host that drops valid mid-burst stalls the channel. Each handshake decrements `beats_left`. The handshake with `beats_left`=1 clears `locked`.
- Size and has_data are sampled only on the first beat. Later beats' `req_size_i` is forwarded but not used for counting.
- The `last_winner` update on a first beat gives the fairness property: no host is starved for more than NumHosts−1 messages.

## Timing
- Zero-cycle forwarding: valid→valid, ready→ready and payload paths are combinational. There is no buffering, and timing is closed by the downstream register slice.
- A grant changes only in the cycle after the last beat handshake of a message (or in IDLE). A back-to-back message from another host is accepted the very next cycle with no bubble.
- Reset (`rst_i`=1 at a clock edge): `locked`=0, `beats_left`=0, `owner`=0, `last_winner`=NumHosts−1, so host 0 has top priority.
- During reset, outputs follow combinational IDLE rules: `locked_o`=0, `grant_idx_o`=0, and `dev_valid_o` mirrors valid inputs. The integration holds hosts invalid during reset.
- Reset mid-burst abandons the burst. The next message starts in IDLE with no residual lock.
- Simultaneous last beat and new requests: the last beat completes, and the next winner is chosen next cycle from `last_winner+1`.
- `dev_ready_i` low in IDLE leaves `last_winner` unchanged. The combinational winner may change if valids change; TileLink rules forbid dropping valid, so a stable winner is not checked.

## Test plan
- Reset, then hosts 0 and 2 both valid with single-beat (has_data=0) messages, ready=1 → host 0 first, then host 2, then host 0 alternating; `locked_o` stays 0.
- Host 1 sends size=6 has_data=1 (4 beats) while hosts 0 and 2 are valid → 4 consecutive beats from host 1 with `locked_o`=1 on beats 2–4; host 2 granted on the next cycle.
- Burst in progress; owner drops valid for 3 cycles mid-burst while others are valid → `dev_valid_o`=0 for those cycles, no other host is granted, and the burst resumes and completes with a total of 4 beats.
- `dev_ready_i` toggled randomly during a size=5 has_data=1 burst (2 beats) → exactly 2 handshakes, `beats_left` reaches 0, `last_winner` updated once.
- Assert `rst_i` after beat 2 of a 4-beat burst → next cycle `locked_o`=0, `grant_idx_o`=0, and host 0 is granted first.
- All 3 hosts continuously valid with single-beat messages for 300 cycles → each host receives 100 ±1 grants, and the maximum wait for any host is 2 messages.
